present_core_frame_scanner: RTL and testbench



---
 rtl/present_core_frame_scanner.sv | 157 +++++++++++++++
 tb/tb_present_core_frame_scanner.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/present_core_frame_scanner.sv
// Raster frame scanner: walks width x height pixels, emitting (x, y, addr) beats on a valid/ready stream.
// Optional registered interrupt output is built when FRAME_SCANNER_IRQ_EN is defined.
module present_core_frame_scanner #(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [31:0]       width_in,
  input  logic [31:0]       height_in,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DIM_W-1:0]  pix_x,
  output logic [DIM_W-1:0]  pix_y,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_last,
  output logic              irq
);

  // state   | meaning
  // IDLE    | waiting for START
  // LOAD    | dimensions latched; zero-size check, counters primed
  // RUN     | emitting one beat per accepted handshake
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]        state;
  logic [DIM_W-1:0]  w_lat, h_lat, x, y;
  logic [ADDR_W-1:0] row_base, stride_lat, base_reg, stride_reg;
  logic              done;
  logic              wr_en, ctrl_wr, start, abort, x_end, y_end, zero_size, frame_end, done_set;
  logic [31:0]       ctrl_rd;

  logic unused_dims;
  assign unused_dims = &{1'b0, width_in[31:DIM_W], height_in[31:DIM_W]};

  assign wr_en     = chipselect && !write_n;
  assign ctrl_wr   = wr_en && (address == 2'd0);
  assign abort     = ctrl_wr && writedata[1];
  assign start     = ctrl_wr && writedata[0] && !writedata[1];
  assign x_end     = (x == w_lat - DIM_W'(1));
  assign y_end     = (y == h_lat - DIM_W'(1));
  assign zero_size = (w_lat == '0) || (h_lat == '0);
  assign frame_end = (state == ST_RUN) && pix_ready && x_end && y_end && !abort;
  assign done_set  = ((state == ST_LOAD) && !abort && zero_size) || frame_end;

  assign pix_valid = (state == ST_RUN);
  assign pix_x     = x;
  assign pix_y     = y;
  assign pix_addr  = row_base + ADDR_W'({x, 2'b00});
  assign pix_last  = (state == ST_RUN) && x_end && y_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      w_lat      <= '0;
      h_lat      <= '0;
      x          <= '0;
      y          <= '0;
      row_base   <= '0;
      stride_lat <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            w_lat <= width_in[DIM_W-1:0];
            h_lat <= height_in[DIM_W-1:0];
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (abort || zero_size) begin
            state <= ST_IDLE;
          end else begin
            x          <= '0;
            y          <= '0;
            row_base   <= base_reg;
            stride_lat <= stride_reg;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (pix_ready) begin
            if (!x_end) begin
              x <= x + DIM_W'(1);
            end else if (!y_end) begin
              // row_base accumulates the stride so no multiplier is needed
              x        <= '0;
              y        <= y + DIM_W'(1);
              row_base <= row_base + stride_lat;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done       <= 1'b0;
      base_reg   <= '0;
      stride_reg <= '0;
    end else begin
      if (done_set) begin
        done <= 1'b1;
      end else if ((state == ST_IDLE) && start) begin
        done <= 1'b0;
      end else if (wr_en && (address == 2'd1) && writedata[1]) begin
        done <= 1'b0;
      end
      if (wr_en && (address == 2'd2)) base_reg   <= ADDR_W'(writedata);
      if (wr_en && (address == 2'd3)) stride_reg <= ADDR_W'(writedata);
    end
  end

`ifdef FRAME_SCANNER_IRQ_EN
  logic irq_en, irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= writedata[2];
      irq_q <= done & irq_en;
    end
  end

  assign irq     = irq_q;
  assign ctrl_rd = {29'b0, irq_en, 2'b0};
`else
  assign irq     = 1'b0;
  assign ctrl_rd = 32'b0;
`endif

  always_comb begin
    readdata = 32'b0;
    case (address)
      2'd0:    readdata = ctrl_rd;
      2'd1:    readdata = {30'b0, done, (state != ST_IDLE)};
      2'd2:    readdata = 32'(base_reg);
      default: readdata = 32'(stride_reg);
    endcase
  end

endmodule

// File: tb/tb_present_core_frame_scanner.sv
// Randomized bench for present_core_frame_scanner; expected beats come from x/y/address arithmetic per frame.
module tb_present_core_frame_scanner;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata, readdata, width_in, height_in;
  logic        pix_valid, pix_ready, pix_last, irq;
  logic [15:0] pix_x, pix_y;
  logic [31:0] pix_addr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  present_core_frame_scanner #(.DIM_W(16), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .width_in(width_in), .height_in(height_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_addr(pix_addr),
    .pix_last(pix_last), .irq(irq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One register write; called just after a falling edge, returns one cycle later.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // mode: 0 ready always high, 1 ready pattern 1,0,0, 2 random ready
  task automatic run_frame(input int w, input int h, input logic [31:0] b, input logic [31:0] s,
                           input int mode, input int abort_at, input bit poke);
    logic [31:0] ea[$];
    int ex[$], ey[$];
    logic [31:0] r, px_addr;
    logic [15:0] px_x, px_y;
    logic        px_last, stalled;
    int total, idx, cyc;
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        ea.push_back(b + 32'(yy) * s + 32'(4 * xx));
        ex.push_back(xx);
        ey.push_back(yy);
      end
    total = w * h;
    width_in = w; height_in = h;
    wr(2'd2, b);
    wr(2'd3, s);
    rd(2'd2, r); check("base_readback", r, b);
    rd(2'd3, r); check("stride_readback", r, s);
    wr(2'd0, 32'h1);
    check("load_no_valid", pix_valid, 1'b0);
    rd(2'd1, r); check("load_status", r, 32'h1);
    if (total == 0) begin
      @(negedge clk);
      rd(2'd1, r); check("zero_status", r, 32'h2);
      check("zero_no_valid", pix_valid, 1'b0);
      repeat (3) begin
        @(negedge clk); #1;
        check("zero_no_valid_later", pix_valid, 1'b0);
      end
      return;
    end
    idx = 0; cyc = 0; stalled = 1'b0;
    px_x = '0; px_y = '0; px_addr = '0; px_last = 1'b0;
    @(negedge clk);
    while (idx < total && cyc < total * 8 + 20) begin
      cyc++;
      if (abort_at >= 0 && idx == abort_at) begin
        pix_ready = 1'b0;
        chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'h2;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        #1;
        check("abort_valid_drop", pix_valid, 1'b0);
        rd(2'd1, r); check("abort_status", r, 32'h0);
        return;
      end
      if (poke && cyc == 3) begin
        chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'h1;
        width_in = 7; height_in = h + 2;
      end else begin
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      end
      case (mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = (cyc % 3 == 1);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      check("valid_in_run", pix_valid, 1'b1);
      if (stalled) begin
        check("stall_x", pix_x, px_x);
        check("stall_y", pix_y, px_y);
        check("stall_addr", pix_addr, px_addr);
        check("stall_last", pix_last, px_last);
      end
      if (pix_ready) begin
        check("beat_x", pix_x, ex[idx]);
        check("beat_y", pix_y, ey[idx]);
        check("beat_addr", pix_addr, ea[idx]);
        check("beat_last", pix_last, idx == total - 1);
        idx++;
        stalled = 1'b0;
      end else begin
        check("stall_last_rule", pix_last, idx == total - 1);
        stalled = 1'b1;
        px_x = pix_x; px_y = pix_y; px_addr = pix_addr; px_last = pix_last;
      end
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1; writedata = '0; pix_ready = 1'b0;
    check("beat_count", idx, total);
    if (mode == 0) check("throughput_cycles", cyc, total);
    #1;
    check("end_valid_drop", pix_valid, 1'b0);
    rd(2'd1, r); check("end_status", r, 32'h2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    width_in = '0; height_in = '0; pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), r); check("reset_reg", r, 32'h0);
    end
    check("reset_valid", pix_valid, 1'b0);
    check("reset_x", pix_x, 16'h0);
    check("reset_y", pix_y, 16'h0);
    check("reset_addr", pix_addr, 32'h0);
    check("reset_last", pix_last, 1'b0);
    check("reset_irq", irq, 1'b0);
    @(negedge clk);

    run_frame(3, 2, 32'h1000, 32'h40, 0, -1, 1'b0);
    run_frame(3, 2, 32'h1000, 32'h40, 1, -1, 1'b0);
    run_frame(5, 0, 32'h2000, 32'h10, 0, -1, 1'b0);
    run_frame(0, 3, 32'h2000, 32'h10, 2, -1, 1'b0);
    run_frame(4, 4, 32'h3000, 32'h100, 0, 5, 1'b0);
    run_frame(4, 4, 32'h3000, 32'h100, 2, -1, 1'b0);
    run_frame(3, 3, 32'h4000, 32'h20, 2, -1, 1'b1);
    run_frame(1, 1, 32'hFFFF_FFF8, 32'h8, 0, -1, 1'b0);
    for (int i = 0; i < 8; i++)
      run_frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)), $urandom, $urandom,
                int'($urandom_range(0, 2)), -1, 1'b0);
    run_frame(5, 3, 32'h5000, 32'h80, 2, int'($urandom_range(1, 14)), 1'b0);

    wr(2'd1, 32'h2);
    rd(2'd1, r); check("done_clear", r, 32'h0);

    wr(2'd0, 32'h4);
    rd(2'd0, r);
`ifdef FRAME_SCANNER_IRQ_EN
    check("ctrl_irq_en_rb", r, 32'h4);
    run_frame(1, 1, 32'h100, 32'h4, 0, -1, 1'b0);
    check("irq_lags_done", irq, 1'b0);
    @(negedge clk); #1;
    check("irq_rise", irq, 1'b1);
    wr(2'd1, 32'h2);
    @(negedge clk); #1;
    check("irq_clear", irq, 1'b0);
`else
    check("ctrl_reads_zero", r, 32'h0);
    run_frame(1, 1, 32'h100, 32'h4, 0, -1, 1'b0);
    repeat (2) begin
      @(negedge clk); #1;
      check("irq_tied_low", irq, 1'b0);
    end
`endif

    // Mid-frame reset must return everything to reset values with no DONE.
    width_in = 4; height_in = 4;
    wr(2'd2, 32'h7000);
    wr(2'd0, 32'h1);
    pix_ready = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_valid", pix_valid, 1'b0);
    check("rst_addr", pix_addr, 32'h0);
    check("rst_x", pix_x, 16'h0);
    rd(2'd1, r); check("rst_status", r, 32'h0);
    rd(2'd2, r); check("rst_base", r, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    pix_ready = 1'b0;
    @(negedge clk);
    run_frame(2, 2, 32'h800, 32'h10, 1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
